// File: rtl/xbus_arbiter_if.sv
// xbus_arbiter_if: two-master picoVersat data bus bundle between masters, arbiter and decoder
// m0_*/m1_* : per-master request, write data, ack, read data and trap flag (M0 also has lock)
// bus_*     : shared decoder-side select, write enable, address, write data, read data, trap
// slave     : the arbiter's view; master: the masters' and decoder's view
interface xbus_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) ();
  logic              m0_req;
  logic              m0_lock;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_data_in;
  logic              m0_ack;
  logic [DATA_W-1:0] m0_data_out;
  logic              m0_err;
  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_data_in;
  logic              m1_ack;
  logic [DATA_W-1:0] m1_data_out;
  logic              m1_err;
  logic              bus_sel;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_data_out;
  logic [DATA_W-1:0] bus_data_in;
  logic              bus_trap;
  modport slave (
    input  m0_req, m0_lock, m0_we, m0_addr, m0_data_in,
    input  m1_req, m1_we, m1_addr, m1_data_in,
    input  bus_data_in, bus_trap,
    output m0_ack, m0_data_out, m0_err,
    output m1_ack, m1_data_out, m1_err,
    output bus_sel, bus_we, bus_addr, bus_data_out
  );
  modport master (
    output m0_req, m0_lock, m0_we, m0_addr, m0_data_in,
    output m1_req, m1_we, m1_addr, m1_data_in,
    output bus_data_in, bus_trap,
    input  m0_ack, m0_data_out, m0_err,
    input  m1_ack, m1_data_out, m1_err,
    input  bus_sel, bus_we, bus_addr, bus_data_out
  );
endinterface

// File: rtl/xbus_arbiter.sv
// xbus_arbiter: round-robin arbiter sharing the picoVersat data bus between the CPU (M0) and game engine (M1)
// clk, rst : system clock, asynchronous active-high reset
// bus      : slave modport of xbus_arbiter_if carrying both master ports and the decoder-side bus
// Each transaction is IDLE (arbitrate) -> ACCESS (bus_sel=1, capture read data/trap) -> ACK (one-cycle ack).
module xbus_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 32,
  parameter int LOCK_MAX = 4
) (
  input logic           clk,
  input logic           rst,
  xbus_arbiter_if.slave bus
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_ACK    = 2'd2;
  localparam logic [3:0] LOCK_LIM = 4'(LOCK_MAX);
  logic [1:0]        r_state;
  logic              r_gnt;
  logic              r_rr_ptr;
  logic              r_lock_pend;
  logic [3:0]        r_lock_cnt;
  logic              w_gnt;
  logic              w_access;
  logic              w_ack;
  logic              w_locked;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  // a pending M0 lock only wins a contested grant while the starvation budget lasts
  assign w_locked = r_lock_pend && (r_lock_cnt < LOCK_LIM);
  assign w_gnt    = (bus.m0_req && bus.m1_req) ? (w_locked ? 1'b0 : r_rr_ptr) : bus.m1_req;
  assign w_access = r_state == S_ACCESS;
  assign w_ack    = r_state == S_ACK;
  assign w_addr   = r_gnt ? bus.m1_addr : bus.m0_addr;
  assign w_wdata  = r_gnt ? bus.m1_data_in : bus.m0_data_in;
  assign bus.bus_sel      = w_access;
  assign bus.bus_we       = w_access && (r_gnt ? bus.m1_we : bus.m0_we);
  assign bus.bus_addr     = w_access ? w_addr : '0;
  assign bus.bus_data_out = w_access ? w_wdata : '0;
  assign bus.m0_ack       = w_ack && !r_gnt;
  assign bus.m1_ack       = w_ack && r_gnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_gnt           <= 1'b0;
      r_rr_ptr        <= 1'b0;
      r_lock_pend     <= 1'b0;
      r_lock_cnt      <= 4'd0;
      bus.m0_data_out <= '0;
      bus.m0_err      <= 1'b0;
      bus.m1_data_out <= '0;
      bus.m1_err      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.m0_req || bus.m1_req) begin
          r_gnt   <= w_gnt;
          r_state <= S_ACCESS;
        end
        S_ACCESS: begin
          if (r_gnt) begin
            bus.m1_data_out <= bus.bus_data_in;
            bus.m1_err      <= bus.bus_trap;
          end else begin
            bus.m0_data_out <= bus.bus_data_in;
            bus.m0_err      <= bus.bus_trap;
          end
          r_state <= S_ACK;
        end
        S_ACK: begin
          r_rr_ptr    <= !r_gnt;
          r_lock_pend <= !r_gnt && bus.m0_lock;
          // r_lock_pend still reflects whether this M0 grant was a locked one
          r_lock_cnt  <= r_gnt ? 4'd0 :
                         (r_lock_pend && r_lock_cnt < LOCK_LIM) ? r_lock_cnt + 4'd1 : r_lock_cnt;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_xbus_arbiter.sv
// tb_xbus_arbiter: directed test of xbus_arbiter against a transaction-timeline model
module tb_xbus_arbiter;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int LM = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  xbus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) xb ();
  xbus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LOCK_MAX(LM)) dut (
    .clk(clk),
    .rst(rst),
    .bus(xb.slave)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, a, e, $time);
    end
  endtask
  // model: a grant at edge gc means ACCESS after edge gc, ACK after gc+1, arbitration again from gc+3
  int       cyc = 0;
  int       gc = -1;
  bit       g = 0;
  bit       rr = 0;
  bit       lpend = 0;
  int       run = 0;
  logic [DW-1:0] mdo [2] = '{default: '0};
  bit       merr [2] = '{default: 1'b0};
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      cyc = 0; gc = -1; g = 0; rr = 0; lpend = 0; run = 0;
      mdo[0] = '0; mdo[1] = '0; merr[0] = 0; merr[1] = 0;
    end else begin
      if (gc >= 0 && cyc == gc + 1) begin
        mdo[g] = xb.bus_data_in;
        merr[g] = xb.bus_trap;
      end
      if (gc >= 0 && cyc == gc + 2) begin
        if (g == 0) begin
          if (lpend && run < LM) run++;
          lpend = xb.m0_lock;
        end else begin
          run = 0;
          lpend = 0;
        end
        rr = !g;
      end
      if ((gc < 0 || cyc >= gc + 3) && (xb.m0_req || xb.m1_req)) begin
        if (xb.m0_req && xb.m1_req) g = (lpend && run < LM) ? 1'b0 : rr;
        else g = xb.m1_req;
        gc = cyc;
      end
      cyc++;
    end
  end
  initial forever begin
    bit acc, ak;
    @(posedge clk);
    #2;
    acc = gc >= 0 && cyc == gc + 1;
    ak  = gc >= 0 && cyc == gc + 2;
    chk("bus_sel", xb.bus_sel, acc);
    chk("bus_we", xb.bus_we, acc && (g ? xb.m1_we : xb.m0_we));
    chk("bus_addr", xb.bus_addr, acc ? (g ? xb.m1_addr : xb.m0_addr) : '0);
    chk("bus_data_out", xb.bus_data_out, acc ? (g ? xb.m1_data_in : xb.m0_data_in) : '0);
    chk("m0_ack", xb.m0_ack, ak && !g);
    chk("m1_ack", xb.m1_ack, ak && g);
    chk("m0_data_out", xb.m0_data_out, mdo[0]);
    chk("m1_data_out", xb.m1_data_out, mdo[1]);
    chk("m0_err", xb.m0_err, merr[0]);
    chk("m1_err", xb.m1_err, merr[1]);
  end
  task automatic wait_ack(output int who, output int n);
    who = -1;
    n = 0;
    while (who < 0 && n < 12) begin
      @(negedge clk);
      n++;
      if (xb.m0_ack) who = 0;
      else if (xb.m1_ack) who = 1;
    end
    if (who < 0) begin
      total++;
      bad++;
      $display("FAIL ack_timeout actual=none expected=ack t=%0t", $time);
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask
  initial begin
    int who, n;
    int exp3 [6] = '{0, 1, 0, 1, 0, 1};
    int exp4 [12] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1};
    xb.m0_req = 1'b1; xb.m0_lock = 1'b0; xb.m0_we = 1'b0; xb.m0_addr = 16'h0010; xb.m0_data_in = '0;
    xb.m1_req = 1'b0; xb.m1_we = 1'b0; xb.m1_addr = '0; xb.m1_data_in = '0;
    xb.bus_data_in = 32'h0000_01A5; xb.bus_trap = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_sel", xb.bus_sel, 1'b0);
    chk("rst_m0_ack", xb.m0_ack, 1'b0);
    chk("rst_addr", xb.bus_addr, '0);
    chk("rst_m0_dout", xb.m0_data_out, '0);
    rst = 1'b0;
    @(negedge clk);
    chk("t1_sel", xb.bus_sel, 1'b1);
    chk("t1_addr", xb.bus_addr, 16'h0010);
    chk("t1_we", xb.bus_we, 1'b0);
    @(negedge clk);
    chk("t1_m0_ack", xb.m0_ack, 1'b1);
    chk("t2_m0_dout", xb.m0_data_out, 32'h0000_01A5);
    chk("t2_m0_err", xb.m0_err, 1'b0);
    chk("t2_m1_ack", xb.m1_ack, 1'b0);
    chk("t2_m1_dout", xb.m1_data_out, '0);
    xb.m0_req = 1'b0;
    @(negedge clk);
    chk("t2_ack_pulse", xb.m0_ack, 1'b0);
    chk("t2_dout_hold", xb.m0_data_out, 32'h0000_01A5);
    do_reset();
    xb.m0_req = 1'b1; xb.m1_req = 1'b1; xb.m0_addr = 16'h0020; xb.m1_addr = 16'h0030;
    xb.bus_data_in = 32'h1234_5678;
    for (int i = 0; i < 6; i++) begin
      wait_ack(who, n);
      chk("t3_gnt", who, exp3[i]);
      chk("t3_gap", n, i == 0 ? 2 : 3);
      xb.bus_data_in = xb.bus_data_in + 32'h11;
    end
    xb.m0_req = 1'b0; xb.m1_req = 1'b0;
    do_reset();
    xb.m0_lock = 1'b1; xb.m0_req = 1'b1; xb.m1_req = 1'b1;
    for (int i = 0; i < 12; i++) begin
      wait_ack(who, n);
      chk("t4_gnt", who, exp4[i]);
      chk("t4_gap", n, i == 0 ? 2 : 3);
    end
    xb.m0_req = 1'b0; xb.m1_req = 1'b0; xb.m0_lock = 1'b0;
    @(negedge clk);
    xb.m1_req = 1'b1; xb.m1_we = 1'b1; xb.m1_addr = 16'hFFF0; xb.m1_data_in = 32'hDEAD_BEEF;
    xb.bus_trap = 1'b1;
    @(negedge clk);
    chk("t5_we", xb.bus_we, 1'b1);
    chk("t5_wdata", xb.bus_data_out, 32'hDEAD_BEEF);
    chk("t5_addr", xb.bus_addr, 16'hFFF0);
    @(negedge clk);
    chk("t5_m1_ack", xb.m1_ack, 1'b1);
    chk("t5_m1_err", xb.m1_err, 1'b1);
    chk("t5_we_off", xb.bus_we, 1'b0);
    xb.m1_req = 1'b0; xb.m1_we = 1'b0; xb.bus_trap = 1'b0;
    @(negedge clk);
    chk("t5_err_hold", xb.m1_err, 1'b1);
    xb.m0_req = 1'b1; xb.m0_addr = 16'h0040;
    wait_ack(who, n);
    chk("t6_pre_gnt", who, 0);
    xb.m0_req = 1'b0;
    @(negedge clk);
    xb.m1_req = 1'b1; xb.m1_addr = 16'h0050;
    @(negedge clk);
    chk("t6_sel", xb.bus_sel, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("t6_async_sel", xb.bus_sel, 1'b0);
    chk("t6_async_addr", xb.bus_addr, '0);
    chk("t6_no_ack", xb.m1_ack, 1'b0);
    @(negedge clk);
    xb.m0_req = 1'b1;
    rst = 1'b0;
    wait_ack(who, n);
    chk("t6_rr_gnt", who, 0);
    chk("t6_rr_gap", n, 2);
    xb.m0_req = 1'b0;
    wait_ack(who, n);
    chk("t6_m1_gnt", who, 1);
    chk("t6_m1_gap", n, 3);
    xb.m1_req = 1'b0;
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/xbus_arbiter.md
Name: xbus_arbiter

Overview:
- Shares the single picoVersat data bus (address, select, write enable, write data, read data) between two masters.
  - M0: the picoVersat CPU.
  - M1: the game engine, which updates ball/object registers and reads the paddles.
- Sits between the two masters and the address decoder. Only its output bus drives the decoder's addr/sel inputs, and the decoder's data_to_rd and trap_sel return through it.
- Round-robin fairness, an M0 lock for atomic read-modify-write, and a per-transaction trap/error report.

Parameters:
- ADDR_W, `ADDR_W, bus address width.
- DATA_W, `DATA_W, bus data width (32).
- LOCK_MAX, 4, maximum consecutive locked M0 grants before M1 must be served (1..15).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- m0_req  input  1  M0 request; held until m0_ack
- m0_lock  input  1  M0 requests that the next grant also go to M0
- m0_we  input  1  M0 write enable
- m0_addr  input  ADDR_W  M0 address
- m0_data_in  input  DATA_W  M0 write data
- m0_ack  output  1  one-cycle transaction-complete pulse
- m0_data_out  output  DATA_W  M0 read data, valid when m0_ack=1
- m0_err  output  1  trap flag, valid when m0_ack=1
- m1_req, m1_we, m1_addr, m1_data_in, m1_ack, m1_data_out, m1_err: same as the M0 ports, for M1 (no lock input)
- bus_sel  output  1  select to the decoder
- bus_we  output  1  write enable to peripherals
- bus_addr  output  ADDR_W  address to the decoder
- bus_data_out  output  DATA_W  write data to peripherals
- bus_data_in  input  DATA_W  decoder read mux output
- bus_trap  input  1  decoder trap select

Behaviour:
- Reset:
  - Reset is asynchronous, active-high.
  - State=IDLE, rr_ptr=0 (M0 preferred), lock_cnt=0.
  - All acks, errs and data_out registers are 0.
  - bus_sel=0, bus_we=0; bus_addr and bus_data_out are 0.
  - Assertion mid-transaction aborts it; no ack is issued.
- States: IDLE, ACCESS, ACK.
- IDLE arbitration (one cycle):
  - Only one request: grant that master.
  - Both requesting: grant master rr_ptr. The exception is m0_lock_pending=1 with lock_cnt<LOCK_MAX, which grants M0.
  - Register gnt and go to ACCESS. With no request, stay in IDLE.
- ACCESS (exactly one cycle):
  - bus_sel=1; bus_we, bus_addr, bus_data_out are driven from the granted master's inputs (combinational mux on registered gnt).
  - Outside ACCESS, bus_sel=0 and bus_we=0. bus_addr and bus_data_out are 0 in IDLE and ACK.
  - At the clock edge, the granted master's data_out captures bus_data_in (captured on writes too) and err captures bus_trap. Go to ACK.
- ACK (one cycle):
  - The granted master's ack=1. The other master's ack=0.
  - rr_ptr becomes the non-granted master.
  - m0_lock_pending is set to m0_lock if gnt=M0, else cleared.
  - lock_cnt increments on a locked M0 grant (saturating at LOCK_MAX) and clears on any M1 grant.
  - Return to IDLE. Requests are not sampled in ACK; the master deasserts req in the ack cycle.
- Timing:
  - Latency is 3 cycles from req sampled in IDLE to ack.
  - Maximum throughput is one transaction per 3 cycles.
  - req held through ack is not treated as a new request.
- Data hold: data_out and err hold their value until that master's next ack.
- Lock starvation bound: if lock_cnt=LOCK_MAX and M1 is requesting, M1 is granted even with M0 locked.
- Master protocol: changing addr/we/data while req=1 before ack is a protocol violation; behaviour is undefined.

Test Plan:
1. Reset with m0_req=1 asserted → all outputs 0; after release, sel=1 at cycle 2 with bus_addr=m0_addr; m0_ack at cycle 3.
2. M0 reads addr 0x10 with bus_data_in=0x0000_01A5 → m0_data_out=0x0000_01A5, m0_err=0, single-cycle ack; M1 outputs unchanged.
3. Both req continuously, no lock, rr_ptr=0 → grants M0, M1, M0, M1…; an ack every 3 cycles.
4. Both req, m0_lock=1 held, LOCK_MAX=4 → 1 unlocked M0 grant, 4 locked M0 grants, then M1 granted; lock_cnt cleared afterwards.
5. M1 write to an unmapped address with bus_trap=1 during ACCESS → m1_err=1 with m1_ack; bus_we=1 only during ACCESS.
6. rst asserted during ACCESS → bus_sel drops asynchronously, no ack; after release, a held req re-arbitrates from IDLE with rr_ptr=0.
